serial_subtractor: RTL and testbench

- Multi-cycle, digit-serial subtractor; the arithmetic inverse of the team's registered adder.
- Accepts two WIDTH-bit unsigned operands over a valid/ready handshake.
- Computes a - b as a WIDTH+1-bit two's-complement result, DIGIT bits per cycle, LSB first, with a rippled borrow.
- Returns the result over a second valid/ready handshake.
- Sits in the arithmetic datapath where area matters more than throughput.

---
 rtl/serial_subtractor_pkg.sv | 29 ++
 rtl/serial_subtractor_sub_digit.sv | 25 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
// The package holds the controller state encoding and the helpers that derive
// the number of digit steps and the width of the digit counter. It also holds
// the configuration legality check that the top level applies at elaboration.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One RUN cycle is spent per digit of the operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width, kept at a minimum of one bit so that a single-digit
  // configuration still has a legal vector.
  function automatic int calc_cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  // The operand must split into whole digits.
  function automatic bit cfg_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// One digit slice of the subtractor, purely combinational.
// Ports:
//   a_d        - minuend digit
//   b_d        - subtrahend digit
//   borrow_in  - borrow from the previous, less significant digit
//   diff_d     - difference digit
//   borrow_out - borrow into the next, more significant digit
module sub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             borrow_in,
  output logic [DIGIT-1:0] diff_d,
  output logic             borrow_out
);

  // The subtraction is done one bit wider than the digit. The extra top bit
  // goes to 1 exactly when the true difference is negative, which is the
  // borrow that the next digit has to absorb.
  always_comb begin
    {borrow_out, diff_d} = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, borrow_in};
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor computing {0,a} - {0,b} modulo 2^(WIDTH+1).
// One DIGIT-bit slice is processed per cycle, LSB first, with a rippled borrow.
// Ports:
//   i_clk, i_rst  - clock and synchronous active-high reset
//   i_valid/o_ready, i_a, i_b   - operand handshake (accepted only in IDLE)
//   o_valid/i_ready, o_diff, o_zero - result handshake; o_diff[WIDTH] is the
//                                     sign (set when a < b), o_zero when a == b
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_diff,
  output logic             o_zero
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_width(NDIG);

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             borrow_q;
  logic [CW-1:0]    digitCnt_q;
  logic             valid_q;
  logic [WIDTH:0]   diff_q;
  logic             zero_q;

  logic [DIGIT-1:0]       digitDiff;
  logic                   digitBorrow;
  logic [WIDTH+DIGIT-1:0] resultShift;
  logic                   lastDigit;

  sub_digit #(
    .DIGIT(DIGIT)
  ) u_sub_digit (
    .a_d       (opA_q[DIGIT-1:0]),
    .b_d       (opB_q[DIGIT-1:0]),
    .borrow_in (borrow_q),
    .diff_d    (digitDiff),
    .borrow_out(digitBorrow)
  );

  // New digits enter from the MSB side so that after NDIG steps the first
  // (least significant) digit has arrived at bit 0. Going through a wider
  // concatenation keeps this legal when DIGIT equals WIDTH.
  always_comb begin
    resultShift = {digitDiff, result_q};
    result_d    = resultShift[WIDTH+DIGIT-1:DIGIT];
    lastDigit   = (digitCnt_q == CW'(NDIG - 1));
  end

  // Controller and datapath registers. Reset takes priority over every
  // handshake, so an operation in flight is simply dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      digitCnt_q <= '0;
      valid_q    <= 1'b0;
      diff_q     <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // o_ready is high whenever we are here out of reset.
          if (i_valid) begin
            opA_q      <= i_a;
            opB_q      <= i_b;
            borrow_q   <= 1'b0;
            digitCnt_q <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          opA_q      <= opA_q >> DIGIT;
          opB_q      <= opB_q >> DIGIT;
          result_q   <= result_d;
          borrow_q   <= digitBorrow;
          digitCnt_q <= digitCnt_q + CW'(1);
          if (lastDigit) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            diff_q  <= {digitBorrow, result_d};
            zero_q  <= (result_d == '0) && !digitBorrow;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = (state_q == IDLE) && !i_rst;
  assign o_valid = valid_q;
  assign o_diff  = diff_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8, DIGIT=2).
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int RW    = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic             outReady;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             outValid;
  logic             inReady;
  logic [WIDTH:0]   diff;
  logic             zero;

  int compareCount = 0;
  int failCount    = 0;

  serial_subtractor #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(inValid),
    .o_ready(outReady),
    .i_a    (opA),
    .i_b    (opB),
    .o_valid(outValid),
    .i_ready(inReady),
    .o_diff (diff),
    .o_zero (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction folded into WIDTH+1 bits.
  function automatic logic [WIDTH:0] refDiff(input int x, input int y);
    int d;
    d = x - y;
    return RW'((d + (1 << RW)) % (1 << RW));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full operation: handshake in, wait for the result, optional
  // backpressure, handshake out. With scramble set, operand inputs and
  // i_valid are perturbed while the block is busy.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH:0] expD, input logic expZ,
                               input int hold, input bit scramble);
    int edges;
    @(negedge clk);
    checkOutput("readyBeforeAccept", outReady, 1);
    opA     = a;
    opB     = b;
    inValid = 1'b1;
    inReady = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("busyNotReady", outReady, 0);
    edges = 0;
    while (!outValid && edges < 20) begin
      if (scramble) begin
        opA     = WIDTH'($urandom);
        opB     = WIDTH'($urandom);
        inValid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("latency", edges, NDIG);
    checkOutput("validUp", outValid, 1);
    checkOutput("diff", diff, expD);
    checkOutput("zero", zero, expZ);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("holdValid", outValid, 1);
      checkOutput("holdDiff", diff, expD);
      checkOutput("holdZero", zero, expZ);
      checkOutput("holdNotReady", outReady, 0);
    end
    inReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("validDropped", outValid, 0);
    checkOutput("readyAgain", outReady, 1);
    checkOutput("diffKept", diff, expD);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst     = 1'b1;
    inValid = 1'b0;
    inReady = 1'b0;
    opA     = '0;
    opB     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReady", outReady, 0);
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstDiff", diff, 0);
    checkOutput("rstZero", zero, 0);
    rst = 1'b0;
    #1;
    checkOutput("readyAfterRst", outReady, 1);

    $display("[TB] directed operations");
    applyStimulus(8'd200, 8'd55,  9'h091, 1'b0, 0, 1'b0);
    applyStimulus(8'd5,   8'd9,   9'h1FC, 1'b0, 0, 1'b0);
    applyStimulus(8'd0,   8'd255, 9'h101, 1'b0, 1, 1'b0);
    applyStimulus(8'd170, 8'd170, 9'h000, 1'b1, 0, 1'b0);
    applyStimulus(8'd255, 8'd0,   9'h0FF, 1'b0, 3, 1'b0);
    applyStimulus(8'd77,  8'd33,  9'h02C, 1'b0, 0, 1'b1);

    $display("[TB] randomized operations");
    for (int i = 0; i < 12; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i == 0) rb = ra;
      applyStimulus(ra, rb, refDiff(int'(ra), int'(rb)), ra == rb,
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during RUN");
    applyStimulus(8'd255, 8'd0, 9'h0FF, 1'b0, 0, 1'b0);
    @(negedge clk);
    opA     = 8'd123;
    opB     = 8'd45;
    inValid = 1'b1;
    inReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstReady", outReady, 0);
    checkOutput("midRstValid", outValid, 0);
    checkOutput("midRstDiff", diff, 0);
    checkOutput("midRstZero", zero, 0);
    rst = 1'b0;
    #1;
    checkOutput("midRstReadyAfter", outReady, 1);
    repeat (NDIG + 2) @(posedge clk);
    @(negedge clk);
    checkOutput("abortedNoResult", outValid, 0);
    applyStimulus(8'd100, 8'd1, 9'h063, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
